// File: rtl/bitand_rr_arbiter_if.sv
// Handshake and datapath bundle between the requesters, the arbiter and the shared AND unit.
interface bitand_rr_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [WIDTH-1:0]         and_a;
    logic [WIDTH-1:0]         and_b;
    logic [WIDTH-1:0]         and_c;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [WIDTH-1:0]         rsp_data;
    logic [ID_W-1:0]          rsp_id;

    modport master (
        output req_valid, req_a, req_b, and_c, rsp_ready,
        input  req_ready, and_a, and_b, rsp_valid, rsp_data, rsp_id
    );

    modport slave (
        input  req_valid, req_a, req_b, and_c, rsp_ready,
        output req_ready, and_a, and_b, rsp_valid, rsp_data, rsp_id
    );
endinterface

// File: rtl/bitand_rr_arbiter.sv
// Round-robin arbiter sharing one AND datapath among NUM_REQ requesters.
// Optional per-requester grant counters: define BITAND_ARB_STATS_EN.
//
// state | meaning
// IDLE  | arbitrate; accept one request and register its operands
// EXEC  | shared unit settles on registered operands; capture result
// RESP  | hold response until rsp_ready
module bitand_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 4,
    parameter int ID_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    bitand_rr_arbiter_if.slave        bus
`ifdef BITAND_ARB_STATS_EN
    ,
    output logic [NUM_REQ*8-1:0]      grant_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t          state, state_nxt;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] winner;
    logic            any_req;
    logic            grant;
    int              idx;

    // First set request strictly after rr_ptr, wrapping.
    always_comb begin
        any_req = 1'b0;
        winner  = '0;
        idx     = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!any_req && bus.req_valid[idx]) begin
                any_req = 1'b1;
                winner  = ID_W'(idx);
            end
        end
    end

    assign grant = rst_n && (state == IDLE) && any_req;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        bus.req_ready = '0;
        unique case (state)
            IDLE: begin
                if (grant) begin
                    bus.req_ready[winner] = 1'b1;
                    state_nxt             = EXEC;
                end
            end
            EXEC:    state_nxt = RESP;
            RESP:    if (bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr        <= ID_W'(NUM_REQ - 1);
            bus.and_a     <= '0;
            bus.and_b     <= '0;
            bus.rsp_data  <= '0;
            bus.rsp_id    <= '0;
            bus.rsp_valid <= 1'b0;
        end else begin
            if (grant) begin
                bus.and_a  <= bus.req_a[int'(winner)*WIDTH +: WIDTH];
                bus.and_b  <= bus.req_b[int'(winner)*WIDTH +: WIDTH];
                bus.rsp_id <= winner;
                rr_ptr     <= winner;
            end
            if (state == EXEC) begin
                bus.rsp_data  <= bus.and_c;
                bus.rsp_valid <= 1'b1;
            end
            if (state == RESP && bus.rsp_ready) bus.rsp_valid <= 1'b0;
        end
    end

`ifdef BITAND_ARB_STATS_EN
    logic [7:0] cnt [NUM_REQ];

    // Saturating so a long-running requester never appears idle after wrap.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!rst_n)
                cnt[i] <= 8'd0;
            else if (grant && winner == ID_W'(i) && cnt[i] != 8'hFF)
                cnt[i] <= cnt[i] + 8'd1;
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt_out
        assign grant_cnt[g*8 +: 8] = cnt[g];
    end
`endif

endmodule

// File: tb/tb_bitand_rr_arbiter.sv
// Randomized and directed bench for bitand_rr_arbiter against a transaction-level model.
module tb_bitand_rr_arbiter;
    localparam int N = 4;
    localparam int W = 4;
    localparam int IW = 2;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    int   cyc;

    bitand_rr_arbiter_if #(.NUM_REQ(N), .WIDTH(W), .ID_W(IW)) bus ();
`ifdef BITAND_ARB_STATS_EN
    logic [N*8-1:0] grant_cnt;
`endif

    bitand_rr_arbiter #(.NUM_REQ(N), .WIDTH(W), .ID_W(IW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef BITAND_ARB_STATS_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    // The shared AND unit.
    assign bus.and_c = bus.and_a & bus.and_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transaction-level reference: who is served, what was sent, how old the job is.
    logic       m_busy;
    int         m_age;
    int         m_last;
    logic [3:0] m_a, m_b, m_data;
    int         m_id;
    int         gcnt [N];
    int         log_q [$];
    int         acc_q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int pick(input logic [3:0] mask);
        for (int k = 1; k <= N; k++) begin
            if (mask[(m_last + k) % N]) return (m_last + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 1'b0; m_age = 0; m_last = N - 1;
        m_a = '0; m_b = '0; m_data = '0; m_id = 0;
        for (int i = 0; i < N; i++) gcnt[i] = 0;
    endtask

    task automatic cycle(input logic [3:0] mask, input logic [15:0] a, input logic [15:0] b,
                         input logic rdy, input logic rst);
        int w;
        logic [3:0] exp_rr;
        @(negedge clk);
        bus.req_valid = mask;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.rsp_ready = rdy;
        rst_n         = rst;
        #1;
        w = pick(mask);
        exp_rr = '0;
        if (rst && !m_busy && mask != 0) exp_rr[w] = 1'b1;
        chk("req_ready", 32'(bus.req_ready), 32'(exp_rr));
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_busy && m_age == 1));
        chk("rsp_data", 32'(bus.rsp_data), 32'(m_data));
        chk("rsp_id", 32'(bus.rsp_id), 32'(m_id));
        chk("and_a", 32'(bus.and_a), 32'(m_a));
        chk("and_b", 32'(bus.and_b), 32'(m_b));
        @(posedge clk);
        cyc++;
        if (!rst) begin
            model_reset();
        end else if (!m_busy) begin
            if (mask != 0) begin
                m_busy = 1'b1; m_age = 0;
                m_a = a[w*4 +: 4]; m_b = b[w*4 +: 4];
                m_id = w; m_last = w;
                log_q.push_back(w); acc_q.push_back(cyc);
                if (gcnt[w] != 255) gcnt[w]++;
            end
        end else if (m_age == 0) begin
            m_age = 1; m_data = m_a & m_b;
        end else if (rdy) begin
            m_busy = 1'b0;
        end
    endtask

`ifdef BITAND_ARB_STATS_EN
    task automatic chk_stats(input string tag);
        for (int i = 0; i < N; i++) chk(tag, 32'(grant_cnt[i*8 +: 8]), 32'(gcnt[i]));
    endtask
`endif

    initial begin
        int exp_order [5];
        n_checks = 0; n_errors = 0; cyc = 0;
        rst_n = 1'b0;
        bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0; bus.rsp_ready = 1'b0;
        model_reset();

        // Reset with all requesting: nothing may be accepted.
        repeat (3) cycle(4'hF, 16'h1234, 16'hFFFF, 1'b1, 1'b0);

        // Single request from requester 0.
        log_q.delete(); acc_q.delete();
        cycle(4'b0001, 16'h0004, 16'h000E, 1'b1, 1'b1);
        repeat (4) cycle(4'b0000, 16'h0000, 16'h0000, 1'b1, 1'b1);
        chk("t1_grants", 32'(log_q.size()), 32'd1);
        if (log_q.size() == 1) chk("t1_id", 32'(log_q[0]), 32'd0);

        // All four requesting continuously from reset.
        cycle(4'b0000, 16'h0, 16'h0, 1'b1, 1'b0);
        log_q.delete(); acc_q.delete();
        repeat (15) cycle(4'hF, 16'h3333, 16'hBBBB, 1'b1, 1'b1);
        exp_order = '{0, 1, 2, 3, 0};
        chk("t2_grants", 32'(log_q.size()), 32'd5);
        if (log_q.size() == 5) begin
            for (int i = 0; i < 5; i++) chk("t2_order", 32'(log_q[i]), 32'(exp_order[i]));
            for (int i = 1; i < 5; i++) chk("t2_spacing", 32'(acc_q[i] - acc_q[i-1]), 32'd3);
        end

        // Backpressure for 5 cycles with everyone still requesting.
        repeat (3) cycle(4'b0000, 16'h0, 16'h0, 1'b1, 1'b1);
        cycle(4'b0100, 16'h0A00, 16'h0600, 1'b0, 1'b1);
        repeat (6) cycle(4'hF, 16'h5555, 16'hAAAA, 1'b0, 1'b1);
        cycle(4'hF, 16'h5555, 16'hAAAA, 1'b1, 1'b1);
        repeat (3) cycle(4'b0000, 16'h0, 16'h0, 1'b1, 1'b1);

        // Requesters 1 and 3 after 3 was last served.
        cycle(4'b0000, 16'h0, 16'h0, 1'b1, 1'b0);
        cycle(4'b1000, 16'hF000, 16'h1000, 1'b1, 1'b1);
        repeat (2) cycle(4'b0000, 16'h0, 16'h0, 1'b1, 1'b1);
        log_q.delete(); acc_q.delete();
        repeat (6) cycle(4'b1010, 16'hFFFF, 16'h1111, 1'b1, 1'b1);
        chk("t4_grants", 32'(log_q.size()), 32'd2);
        if (log_q.size() == 2) begin
            chk("t4_first", 32'(log_q[0]), 32'd1);
            chk("t4_second", 32'(log_q[1]), 32'd3);
        end

        // Reset while in EXEC; next grant goes to requester 0.
        repeat (2) cycle(4'b0000, 16'h0, 16'h0, 1'b1, 1'b1);
        cycle(4'b0100, 16'h0700, 16'h0300, 1'b1, 1'b1);
        cycle(4'b0000, 16'h0, 16'h0, 1'b1, 1'b0);
        log_q.delete(); acc_q.delete();
        cycle(4'hF, 16'h9999, 16'hCCCC, 1'b1, 1'b1);
        chk("t5_grants", 32'(log_q.size()), 32'd1);
        if (log_q.size() == 1) chk("t5_id", 32'(log_q[0]), 32'd0);
        repeat (3) cycle(4'b0000, 16'h0, 16'h0, 1'b1, 1'b1);

        // Random traffic with random backpressure and rare resets.
        for (int i = 0; i < 600; i++) begin
            cycle(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom),
                  ($urandom_range(0, 9) < 7), ($urandom_range(0, 79) != 0));
        end
`ifdef BITAND_ARB_STATS_EN
        chk_stats("rand_cnt");

        // Saturation: 300 grants to requester 2.
        cycle(4'b0000, 16'h0, 16'h0, 1'b1, 1'b0);
        for (int i = 0; i < 300; i++) begin
            cycle(4'b0100, 16'h0F00, 16'h0500, 1'b1, 1'b1);
            repeat (2) cycle(4'b0000, 16'h0, 16'h0, 1'b1, 1'b1);
        end
        chk("sat_cnt2", 32'(grant_cnt[23:16]), 32'hFF);
        chk_stats("sat_cnt");
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
